// File: rtl/rgb_s_axis_receiver.sv
// AXI4-Stream RGB slave: buffers {tuser, tlast, tdata} beats in a small FIFO and
// re-times them onto a ready/valid pixel port with x/y coordinates and line checks.
module rgb_s_axis_receiver #(
    parameter int C_rgb_s_axis_TDATA_WIDTH = 16,
    parameter int img_width                = 1080,
    parameter int FIFO_DEPTH               = 16,
    parameter int CNT_WIDTH                = 12
) (
    input  logic                                rgb_s_axis_aclk,
    input  logic                                rgb_s_axis_aresetn,
    input  logic                                enable,
    input  logic [C_rgb_s_axis_TDATA_WIDTH-1:0] rgb_s_axis_tdata,
    input  logic                                rgb_s_axis_tvalid,
    input  logic                                rgb_s_axis_tuser,
    input  logic                                rgb_s_axis_tlast,
    output logic                                rgb_s_axis_tready,
    output logic [C_rgb_s_axis_TDATA_WIDTH-1:0] pix_data,
    output logic                                pix_valid,
    input  logic                                pix_ready,
    output logic                                pix_sof,
    output logic                                pix_eol,
    output logic [CNT_WIDTH-1:0]                pix_x,
    output logic [CNT_WIDTH-1:0]                pix_y,
    output logic                                err_early_eol,
    output logic                                err_late_eol,
    output logic                                err_early_sof,
    output logic [31:0]                         frame_count
);

    localparam int DW  = C_rgb_s_axis_TDATA_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int EW  = DW + 2;
    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(img_width - 1);
    localparam logic [CNT_WIDTH-1:0] Y_MAX  = '1;

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t               state, state_next;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, wr_ptr_vis, rd_ptr, fill_next;
    logic                 push, pop, avail, hs, en_d, en_rise, can_load, load;
    logic                 head_user, head_last;
    logic [DW-1:0]        head_data;
    logic                 at_x_last, sof_err;
    logic [CNT_WIDTH-1:0] nxt_x, nxt_y, adv_x, adv_y, pos_x, pos_y;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == Y_MAX) ? v : v + 1'b1;
    endfunction

    assign push      = rgb_s_axis_tvalid && rgb_s_axis_tready;
    // Egress compares against a one-cycle-delayed write pointer, so a fresh beat
    // becomes poppable the cycle after it is written.
    assign avail     = (wr_ptr_vis != rd_ptr);
    assign fill_next = wr_ptr + AW1'(push) - rd_ptr - AW1'(pop);
    assign {head_user, head_last, head_data} = mem[rd_ptr[AW-1:0]];
    assign hs        = pix_valid && pix_ready;
    assign en_rise   = enable && !en_d;
    assign can_load  = avail && (!pix_valid || pix_ready) && !en_rise;
    assign at_x_last = (pix_x == X_LAST);

    always_ff @(posedge rgb_s_axis_aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {rgb_s_axis_tuser, rgb_s_axis_tlast, rgb_s_axis_tdata};
    end

    always_ff @(posedge rgb_s_axis_aclk or negedge rgb_s_axis_aresetn) begin
        if (!rgb_s_axis_aresetn) begin
            wr_ptr            <= '0;
            wr_ptr_vis        <= '0;
            rd_ptr            <= '0;
            rgb_s_axis_tready <= 1'b0;
            en_d              <= 1'b0;
        end else begin
            wr_ptr            <= wr_ptr + AW1'(push);
            wr_ptr_vis        <= wr_ptr;
            rd_ptr            <= rd_ptr + AW1'(pop);
            // fill_next never exceeds FIFO_DEPTH, so its MSB alone flags "full".
            rgb_s_axis_tready <= enable && !fill_next[AW];
            en_d              <= enable;
        end
    end

    // Coordinate the next popped entry takes, accounting for a same-cycle handshake.
    always_comb begin
        adv_x = pix_x + 1'b1;
        adv_y = pix_y;
        if (pix_eol || at_x_last) begin
            adv_x = '0;
            adv_y = sat_inc(pix_y);
        end
        pos_x = hs ? adv_x : nxt_x;
        pos_y = hs ? adv_y : nxt_y;
    end

    always_ff @(posedge rgb_s_axis_aclk or negedge rgb_s_axis_aresetn) begin
        if (!rgb_s_axis_aresetn) state <= WAIT_SOF;
        else                     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        if (en_rise) begin
            state_next = WAIT_SOF;
        end else if (can_load) begin
            pop = 1'b1;
            case (state)
                WAIT_SOF: begin
                    if (head_user) begin
                        load       = 1'b1;
                        state_next = ACTIVE;
                    end
                end
                ACTIVE:   load = 1'b1;
                default:  state_next = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge rgb_s_axis_aclk or negedge rgb_s_axis_aresetn) begin
        if (!rgb_s_axis_aresetn) begin
            pix_valid     <= 1'b0;
            pix_data      <= '0;
            pix_sof       <= 1'b0;
            pix_eol       <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            sof_err       <= 1'b0;
            nxt_x         <= '0;
            nxt_y         <= '0;
            err_early_eol <= 1'b0;
            err_late_eol  <= 1'b0;
            err_early_sof <= 1'b0;
            frame_count   <= '0;
        end else begin
            if (load) begin
                pix_valid <= 1'b1;
                pix_data  <= head_data;
                pix_sof   <= head_user;
                pix_eol   <= head_last;
                if (head_user) begin
                    pix_x   <= '0;
                    pix_y   <= '0;
                    sof_err <= (state == ACTIVE) && (pos_x != '0);
                end else begin
                    pix_x   <= pos_x;
                    pix_y   <= pos_y;
                    sof_err <= 1'b0;
                end
            end else if (hs) begin
                pix_valid <= 1'b0;
            end
            if (en_rise) begin
                nxt_x <= '0;
                nxt_y <= '0;
            end else if (hs) begin
                nxt_x <= adv_x;
                nxt_y <= adv_y;
            end
            // Line/frame checks are judged on the pixel as it leaves the port.
            err_early_eol <= hs && pix_eol && !at_x_last;
            err_late_eol  <= hs && !pix_eol && at_x_last;
            err_early_sof <= hs && pix_sof && sof_err;
            frame_count   <= frame_count + 32'(hs && pix_sof);
        end
    end

endmodule

// File: tb/tb_rgb_s_axis_receiver.sv
// Scoreboard bench for rgb_s_axis_receiver with img_width=4, FIFO_DEPTH=16.
module tb_rgb_s_axis_receiver;
    localparam int W = 4, DEPTH = 16, CW = 12, DW = 16;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, tready;
    logic [DW-1:0] pix_data;
    logic pix_valid, pix_ready = 1'b1, pix_sof, pix_eol;
    logic [CW-1:0] pix_x, pix_y;
    logic err_early_eol, err_late_eol, err_early_sof;
    logic [31:0] frame_count;

    always #5 clk = ~clk;

    rgb_s_axis_receiver #(.C_rgb_s_axis_TDATA_WIDTH(DW), .img_width(W),
                          .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .rgb_s_axis_aclk(clk), .rgb_s_axis_aresetn(rst_n), .enable(enable),
        .rgb_s_axis_tdata(tdata), .rgb_s_axis_tvalid(tvalid), .rgb_s_axis_tuser(tuser),
        .rgb_s_axis_tlast(tlast), .rgb_s_axis_tready(tready),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_x(pix_x), .pix_y(pix_y),
        .err_early_eol(err_early_eol), .err_late_eol(err_late_eol),
        .err_early_sof(err_early_sof), .frame_count(frame_count));

    typedef struct {
        logic [DW-1:0] data;
        logic sof, eol;
        logic [CW-1:0] x, y;
        logic ee, le, es;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0;
    logic [2:0] pend_err = 3'b000;
    int cnt_ee = 0, cnt_le = 0, cnt_es = 0;
    int m_ee = 0, m_le = 0, m_es = 0, m_frames = 0;
    bit m_active = 1'b0;
    logic [CW-1:0] m_nx = '0, m_ny = '0;
    logic [DW-1:0] seq = 16'h0100;

    // Reference behaviour of one accepted beat; pushes the pixel it should produce.
    task automatic model_beat(input logic [DW-1:0] d, input logic u, input logic l);
        exp_t e;
        if (!m_active && !u) return;
        e.data = d; e.sof = u; e.eol = l;
        if (u) begin
            e.x = '0; e.y = '0;
            e.es = m_active && (m_nx != 0);
            m_frames++;
        end else begin
            e.x = m_nx; e.y = m_ny; e.es = 1'b0;
        end
        e.ee = l && (e.x != CW'(W - 1));
        e.le = !l && (e.x == CW'(W - 1));
        if (l || e.x == CW'(W - 1)) begin
            m_nx = '0;
            m_ny = (e.y == '1) ? e.y : e.y + 1'b1;
        end else begin
            m_nx = e.x + 1'b1;
            m_ny = e.y;
        end
        m_active = 1'b1;
        if (e.ee) m_ee++;
        if (e.le) m_le++;
        if (e.es) m_es++;
        sb.push_back(e);
    endtask

    task automatic model_clear();
        sb.delete();
        m_active = 1'b0; m_nx = '0; m_ny = '0;
        m_frames = 0; m_ee = 0; m_le = 0; m_es = 0;
        cnt_ee = 0; cnt_le = 0; cnt_es = 0;
        pend_err = 3'b000;
    endtask

    // Per-cycle scoreboard consumer, sampled on the falling edge.
    task automatic mon_negedge();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            pend_err = 3'b000;
            return;
        end
        total++;
        if ({err_early_eol, err_late_eol, err_early_sof} !== pend_err) begin
            bad++;
            $display("FAIL err_pulses got=%b want=%b t=%0t",
                     {err_early_eol, err_late_eol, err_early_sof}, pend_err, $time);
        end
        if (err_early_eol) cnt_ee++;
        if (err_late_eol) cnt_le++;
        if (err_early_sof) cnt_es++;
        pend_err = 3'b000;
        if (pix_valid && pix_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pixel got data=%h x=%0d y=%0d want none", pix_data, pix_x, pix_y);
            end else begin
                e = sb.pop_front();
                if ({pix_data, pix_sof, pix_eol, pix_x, pix_y} !== {e.data, e.sof, e.eol, e.x, e.y}) begin
                    bad++;
                    $display("FAIL pixel got d=%h sof=%b eol=%b x=%0d y=%0d want d=%h sof=%b eol=%b x=%0d y=%0d",
                             pix_data, pix_sof, pix_eol, pix_x, pix_y, e.data, e.sof, e.eol, e.x, e.y);
                end
                pend_err = {e.ee, e.le, e.es};
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin mon_negedge(); next_edge(); end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
        int waitc = 0;
        tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
        mon_negedge();
        while (!tready && waitc < 200) begin
            next_edge(); mon_negedge(); waitc++;
        end
        total++;
        if (!tready) begin
            bad++;
            $display("FAIL send_timeout got tready=0 want 1 data=%h", d);
        end else begin
            model_beat(d, u, l);
        end
        next_edge();
        tvalid = 1'b0;
    endtask

    task automatic send_proper(input int n);
        for (int i = 0; i < n; i++) begin
            send(seq, 1'b0, m_nx == CW'(W - 1));
            seq++;
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((sb.size() != 0 || pix_valid) && i < 300) begin
            mon_negedge(); next_edge(); i++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got left=%0d want 0", sb.size());
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        next_edge(); next_edge();
        total++;
        if ({tready, pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y, err_early_eol,
             err_late_eol, err_early_sof, frame_count} !== '0) begin
            bad++;
            $display("FAIL reset_values got valid=%b d=%h x=%0d y=%0d fc=%0d want all 0",
                     pix_valid, pix_data, pix_x, pix_y, frame_count);
        end
        rst_n = 1'b1;
        idle(1);
        total++;
        if (tready !== 1'b0) begin bad++; $display("FAIL tready_disabled got=%b want=0", tready); end
        enable = 1'b1;
        idle(1);
        mon_negedge();
        total++;
        if (tready !== 1'b1) begin bad++; $display("FAIL tready_enabled got=%b want=1", tready); end
        next_edge();
    endtask

    task automatic test_discard_frame();
        for (int i = 0; i < 5; i++) begin send(seq, 1'b0, i == 2); seq++; end
        send(seq, 1'b1, 1'b0); seq++;
        send_proper(11);
        drain();
        total++;
        if (frame_count !== 32'd1) begin bad++; $display("FAIL frame_count_first got=%0d want=1", frame_count); end
        total++;
        if (cnt_ee + cnt_le + cnt_es != 0) begin
            bad++; $display("FAIL clean_frame_errors got=%0d want=0", cnt_ee + cnt_le + cnt_es);
        end
    endtask

    task automatic test_latency();
        tdata = seq; tuser = 1'b1; tlast = 1'b0; tvalid = 1'b1;
        mon_negedge();
        total++;
        if (tready !== 1'b1) begin bad++; $display("FAIL latency_tready got=%b want=1", tready); end
        else model_beat(seq, 1'b1, 1'b0);
        seq++;
        next_edge();
        tvalid = 1'b0;
        idle(1);
        mon_negedge();
        total++;
        if (pix_valid !== 1'b0) begin bad++; $display("FAIL latency_k1 got valid=%b want=0", pix_valid); end
        next_edge();
        mon_negedge();
        total++;
        if (pix_valid !== 1'b1) begin bad++; $display("FAIL latency_k2 got valid=%b want=1", pix_valid); end
        next_edge();
        send_proper(11);
        drain();
        total++;
        if (frame_count !== 32'd2) begin bad++; $display("FAIL frame_count_second got=%0d want=2", frame_count); end
    endtask

    task automatic test_eol_errors();
        send(seq, 1'b0, 1'b0); seq++;
        send(seq, 1'b0, 1'b0); seq++;
        send(seq, 1'b0, 1'b1); seq++;
        for (int i = 0; i < 5; i++) begin send(seq, 1'b0, 1'b0); seq++; end
        while (m_nx != 0) send_proper(1);
        drain();
        total++;
        if (cnt_ee !== 1) begin bad++; $display("FAIL early_eol_count got=%0d want=1", cnt_ee); end
        total++;
        if (cnt_le !== 1) begin bad++; $display("FAIL late_eol_count got=%0d want=1", cnt_le); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        pix_ready = 1'b0;
        send_proper(1);
        idle(4);
        total++;
        if (pix_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got valid=%b want=1", pix_valid); end
        tdata = seq; tuser = 1'b0; tlast = (m_nx == CW'(W - 1)); tvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mon_negedge();
            if (tready) begin
                model_beat(tdata, tuser, tlast);
                acc++;
                next_edge();
                seq++;
                tdata = seq; tlast = (m_nx == CW'(W - 1));
            end else begin
                next_edge();
            end
        end
        tvalid = 1'b0;
        total++;
        if (acc !== DEPTH) begin bad++; $display("FAIL accepts_when_stalled got=%0d want=%0d", acc, DEPTH); end
        total++;
        if (tready !== 1'b0) begin bad++; $display("FAIL tready_full got=%b want=0", tready); end
        pix_ready = 1'b1;
        drain();
        total++;
        if (cnt_le !== m_le) begin bad++; $display("FAIL late_eol_model got=%0d want=%0d", cnt_le, m_le); end
    endtask

    task automatic test_early_sof();
        int es_before;
        while (m_nx != 0) send_proper(1);
        send(seq, 1'b1, 1'b0); seq++;
        send_proper(5);
        es_before = cnt_es;
        send(seq, 1'b1, 1'b0); seq++;
        drain();
        total++;
        if (cnt_es !== es_before + 1) begin
            bad++; $display("FAIL early_sof_pulse got=%0d want=%0d", cnt_es, es_before + 1);
        end
        total++;
        if (frame_count !== 32'(m_frames)) begin
            bad++; $display("FAIL frame_count_sof got=%0d want=%0d", frame_count, m_frames);
        end
    endtask

    task automatic test_enable_toggle();
        enable = 1'b0;
        idle(1);
        mon_negedge();
        total++;
        if (tready !== 1'b0) begin bad++; $display("FAIL tready_drop got=%b want=0", tready); end
        next_edge();
        enable = 1'b1;
        m_active = 1'b0; m_nx = '0; m_ny = '0;
        idle(1);
        mon_negedge();
        total++;
        if (tready !== 1'b1) begin bad++; $display("FAIL tready_rise got=%b want=1", tready); end
        next_edge();
        send(seq, 1'b0, 1'b0); seq++;
        send(seq, 1'b1, 1'b0); seq++;
        send_proper(3);
        drain();
        total++;
        if (cnt_es !== m_es) begin bad++; $display("FAIL sof_after_enable got=%0d want=%0d", cnt_es, m_es); end
    endtask

    task automatic test_reset_mid();
        pix_ready = 1'b0;
        send(seq, 1'b1, 1'b0); seq++;
        send_proper(2);
        idle(4);
        mon_negedge();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({tready, pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y, err_early_eol,
             err_late_eol, err_early_sof, frame_count} !== '0) begin
            bad++;
            $display("FAIL async_reset got valid=%b d=%h x=%0d y=%0d fc=%0d want all 0",
                     pix_valid, pix_data, pix_x, pix_y, frame_count);
        end
        model_clear();
        next_edge();
        next_edge();
        rst_n = 1'b1;
        pix_ready = 1'b1;
        send(seq, 1'b0, 1'b0); seq++;
        send(seq, 1'b0, 1'b1); seq++;
        send(seq, 1'b1, 1'b0); seq++;
        send_proper(3);
        drain();
        total++;
        if (frame_count !== 32'd1) begin bad++; $display("FAIL frame_count_after_reset got=%0d want=1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_discard_frame();
        test_latency();
        test_eol_errors();
        test_backpressure();
        test_early_sof();
        test_enable_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_s_axis_receiver.md
# rgb_s_axis_receiver

Slave-side AXI4-Stream video receiver: accepts 16-bit RGB beats (`tuser` = start-of-frame, `tlast` = end-of-line) from the stream master and buffers them in a small FIFO. It re-times them onto a ready/valid pixel interface with pixel/line coordinates, and checks line length against `img_width`. It sits at the input of the video frame-processing pipeline, consuming what the `rgb_m_axis` master side produces.

## Interface
- `C_rgb_s_axis_TDATA_WIDTH`, 16, stream data width
- `img_width`, 1080, expected beats per line
- `FIFO_DEPTH`, 16, ingress buffer entries (power of 2, ≥4)
- `CNT_WIDTH`, 12, width of x/y coordinate counters
- `rgb_s_axis_aclk`  in  1  sole clock
- `rgb_s_axis_aresetn`  in  1  asynchronous active-low reset
- `enable`  in  1  receive enable
- `rgb_s_axis_tdata`  in  C_rgb_s_axis_TDATA_WIDTH  pixel data
- `rgb_s_axis_tvalid`  in  1  beat valid
- `rgb_s_axis_tuser`  in  1  start of frame
- `rgb_s_axis_tlast`  in  1  end of line
- `rgb_s_axis_tready`  out  1  beat accept
- `pix_data`  out  C_rgb_s_axis_TDATA_WIDTH  output pixel
- `pix_valid`  out  1  output valid
- `pix_ready`  in  1  downstream accept
- `pix_sof`, `pix_eol`  out  1 each  frame start / line end, qualified by `pix_valid`
- `pix_x`, `pix_y`  out  CNT_WIDTH each  coordinates of the current pixel
- `err_early_eol`, `err_late_eol`, `err_early_sof`  out  1 each  single-cycle error pulses
- `frame_count`  out  32  completed-SOF counter

## Operation
- Ingress:
  - `tready = enable && (fifo_count < FIFO_DEPTH)`, registered.
  - A beat is written on `tvalid && tready`. The entry stores {tuser, tlast, tdata}.
- Egress FSM, two states:
  - WAIT_SOF (reset state): pop FIFO entries with tuser=0 and discard them (one per cycle, `pix_valid` stays 0). An entry with tuser=1 is presented with x=0, y=0 and `pix_sof=1`, and the FSM moves to ACTIVE.
  - ACTIVE: each popped entry is presented at the next coordinate. After the output handshake (`pix_valid && pix_ready`):
    - tlast=1 with x==img_width-1: x←0, y←y+1.
    - tlast=1 with x<img_width-1: `err_early_eol` pulse, x←0, y←y+1.
    - tlast=0 with x==img_width-1: `err_late_eol` pulse, x←0, y←y+1.
    - otherwise x←x+1.
  - Entry with tuser=1 while in ACTIVE: it starts a new frame (x=0, y=0, `pix_sof=1`). If that frame start is not at x=0, `err_early_sof` pulses.
- `frame_count` increments by 1 on each presented SOF pixel, when its handshake completes. It wraps modulo 2^32.
- `y` saturates at 2^CNT_WIDTH−1.
- Output register holds `pix_data`, `pix_sof`, `pix_eol`, `pix_x`, `pix_y` stable while `pix_valid && !pix_ready`.
- A new FIFO entry is popped into the output register only when the register is empty or is being handshaken in the same cycle. This gives full throughput at 1 pixel/cycle.
- `enable` deassert: `tready` drops on the next edge, and FIFO contents continue to drain. An `enable` 0→1 transition forces the FSM to WAIT_SOF and clears x/y.
- `pix_ready` low for longer than FIFO_DEPTH beats fills the FIFO and deasserts `tready`. No beat is ever lost or duplicated.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `tready=0`, `pix_valid=0`, `pix_sof=0`, `pix_eol=0`, `pix_data=0`, `pix_x=0`, `pix_y=0`, all error pulses 0, `frame_count=0`.
  - FSM in WAIT_SOF, FIFO empty.
- Reset mid-frame: everything returns to the reset state immediately and FIFO contents are discarded.
- Latency: a beat accepted at edge k (empty FIFO, `pix_ready=1`) drives `pix_valid` high after edge k+2.
- `tready` rises 1 cycle after `enable` rises, when the FIFO is not full.
- Error pulses and the `frame_count` update are registered, asserting in the cycle after the offending output handshake.
- Simultaneous FIFO push and pop when full: the push is not allowed, because `tready` was already 0 (registered full).
- Simultaneous FIFO push and pop when empty: the pushed entry is visible to egress on the next cycle.

## Test plan
- Reset, then `enable=1`, one 4×3 frame (`img_width=4`), `pix_ready=1` -> 12 pixels with x 0..3, y 0..2, `pix_sof` on the first only, `pix_eol` on x=3, `frame_count=1`, no error pulses.
- 5 beats with tuser=0, then SOF frame -> the 5 beats are discarded with no `pix_valid`, and output starts at the SOF pixel with x=0, y=0.
- Line with tlast at x=2 (`img_width=4`) -> `err_early_eol` for 1 cycle, next pixel at x=0, y+1. Line of 5 beats with no tlast -> `err_late_eol` at x=3, and the 5th beat appears at x=0, y+1.
- `pix_ready` held 0 for 40 cycles with `tvalid=1` -> `tready` drops after 16 accepts (FIFO_DEPTH=16). On release, all beats come out in order with no loss or duplication.
- tuser=1 at x=2, y=1 -> `err_early_sof` pulse, new pixel at x=0, y=0, `frame_count` incremented.
- Assert `rgb_s_axis_aresetn` low mid-line -> all outputs at reset values asynchronously. After release, the block waits for SOF again.
